// File: rtl/alu_nibble_seq_pkg.sv
// Shared types and constants for the nibble-serial ALU sequencer.
// Holds the FSM state encoding, the ADD opcode and the slice width.
package alu_nibble_seq_pkg;

   localparam int NIB_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // {l, aluop} pattern that selects the chained adder
   localparam logic [2:0] OP_ADD = {1'b0, 2'b10};

   function automatic logic is_add(input logic l, input logic [1:0] aluop);
      return {l, aluop} == OP_ADD;
   endfunction

   // Logic-unit ops are always legal; the adder is only legal for ADD
   function automatic logic is_legal(input logic l, input logic [1:0] aluop);
      return l || is_add(l, aluop);
   endfunction

endpackage

// File: rtl/alu_nibble_seq_nib_sel.sv
// Combinational slice mux: picks nibble idx out of a W-bit word.
// Written as a compare-and-select loop so non-power-of-two NIBBLES stay in range.
module alu_nibble_seq_nib_sel
   import alu_nibble_seq_pkg::*;
#(
   parameter int NIBBLES = 4,
   localparam int W     = NIB_W * NIBBLES,
   localparam int IDX_W = $clog2(NIBBLES)
) (
   input  logic [W-1:0]     data,
   input  logic [IDX_W-1:0] idx,
   output logic [NIB_W-1:0] nib
);

   always_comb begin
      // NOTE: assigning a default before the loop keeps this purely combinational (no latch).
      nib = '0;
      for (int i = 0; i < NIBBLES; i++) begin
         if (idx == IDX_W'(i)) nib = data[NIB_W*i +: NIB_W];
      end
   end

endmodule

// File: rtl/alu_nibble_seq.sv
// Runs wide ADD / logic operations through an external 4-bit ALU, one nibble
// per clock LSB first, with valid/ready handshakes on request and result.
module alu_nibble_seq
   import alu_nibble_seq_pkg::*;
#(
   parameter int NIBBLES = 4,
   localparam int W     = NIB_W * NIBBLES,
   localparam int IDX_W = $clog2(NIBBLES)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   input  logic             cin,
   input  logic             l,
   input  logic [1:0]       aluop,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     result,
   output logic             cout,
   output logic             zero,
   output logic             sign,
   output logic             err,
   output logic [NIB_W-1:0] alu_a,
   output logic [NIB_W-1:0] alu_b,
   output logic             alu_cin,
   output logic [1:0]       alu_op,
   output logic             alu_l,
   input  logic [NIB_W-1:0] alu_r,
   input  logic             alu_cout,
   input  logic             alu_zero,
   input  logic             alu_sign
);

   localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

   state_t           state, state_nx;
   logic [W-1:0]     a_q, b_q;
   logic             l_q;
   logic [1:0]       op_q;
   logic [IDX_W-1:0] idx;
   logic             carry;
   logic             zacc;
   logic [NIB_W-1:0] a_nib, b_nib;
   logic             add_q;
   logic             accept;

   assign add_q  = is_add(l_q, op_q);
   assign accept = (state == IDLE) && in_valid;

   // NOTE: operand registers are only read in RUN after being loaded, so they need no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         a_q  <= a;
         b_q  <= b;
         l_q  <= l;
         op_q <= aluop;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= IDLE;
         idx    <= '0;
         carry  <= 1'b0;
         zacc   <= 1'b1;
         result <= '0;
         cout   <= 1'b0;
         zero   <= 1'b0;
         sign   <= 1'b0;
         err    <= 1'b0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: if (in_valid) begin
               idx    <= '0;
               carry  <= is_add(l, aluop) ? cin : 1'b0;
               zacc   <= 1'b1;
               result <= '0;
               cout   <= 1'b0;
               zero   <= 1'b0;
               sign   <= 1'b0;
               err    <= !is_legal(l, aluop);
            end
            RUN: begin
               result[NIB_W*int'(idx) +: NIB_W] <= alu_r;
               carry <= add_q ? alu_cout : 1'b0;
               zacc  <= zacc & alu_zero;
               idx   <= (idx == LAST) ? '0 : idx + 1'b1;
               // Final flags are taken from the last slice as DONE is entered
               if (idx == LAST) begin
                  sign <= alu_sign;
                  cout <= add_q ? alu_cout : 1'b0;
                  zero <= zacc & alu_zero;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (in_valid) state_nx = is_legal(l, aluop) ? RUN : DONE;
         RUN:     if (idx == LAST) state_nx = DONE;
         DONE:    if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   alu_nibble_seq_nib_sel #(.NIBBLES(NIBBLES)) u_sel_a (.data(a_q), .idx(idx), .nib(a_nib));
   alu_nibble_seq_nib_sel #(.NIBBLES(NIBBLES)) u_sel_b (.data(b_q), .idx(idx), .nib(b_nib));

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
      alu_a     = '0;
      alu_b     = '0;
      alu_cin   = 1'b0;
      alu_l     = 1'b1;
      alu_op    = 2'b00;
      if (state == RUN) begin
         alu_a   = a_nib;
         alu_b   = b_nib;
         alu_cin = carry;
         alu_l   = l_q;
         alu_op  = op_q;
      end
   end

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Directed bench for alu_nibble_seq: a 4-nibble and a 2-nibble instance,
// each wired to a behavioural 4-bit ALU.
module tb_alu_nibble_seq;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // 4-bit ALU stand-in: returns {cout, zero, sign, r}
   function automatic logic [6:0] alu_model(input logic [3:0] x, input logic [3:0] y,
                                            input logic ci, input logic lm, input logic [1:0] op);
      logic [4:0] s;
      logic [3:0] r;
      logic       co;
      co = 1'b0;
      if (!lm) begin
         s  = {1'b0, x} + {1'b0, y} + {4'b0, ci};
         r  = s[3:0];
         co = s[4];
      end else begin
         case (op)
            2'b00:   r = x & y;
            2'b01:   r = x | y;
            2'b10:   r = x ^ y;
            default: r = ~(x | y);
         endcase
      end
      return {co, (r == 4'h0), r[3], r};
   endfunction

   // ---------------- NIBBLES = 4 instance ----------------
   logic        in_valid4, in_ready4, cin4, l4, out_valid4, out_ready4;
   logic [1:0]  aluop4, alu_op4;
   logic [15:0] a4, b4, result4;
   logic        cout4, zero4, sign4, err4;
   logic [3:0]  alu_a4, alu_b4, alu_r4;
   logic        alu_cin4, alu_l4, alu_cout4, alu_zero4, alu_sign4;

   always_comb {alu_cout4, alu_zero4, alu_sign4, alu_r4} =
      alu_model(alu_a4, alu_b4, alu_cin4, alu_l4, alu_op4);

   alu_nibble_seq #(.NIBBLES(4)) u_dut4 (
      .clk(clk), .reset(reset),
      .in_valid(in_valid4), .in_ready(in_ready4),
      .a(a4), .b(b4), .cin(cin4), .l(l4), .aluop(aluop4),
      .out_valid(out_valid4), .out_ready(out_ready4),
      .result(result4), .cout(cout4), .zero(zero4), .sign(sign4), .err(err4),
      .alu_a(alu_a4), .alu_b(alu_b4), .alu_cin(alu_cin4), .alu_op(alu_op4), .alu_l(alu_l4),
      .alu_r(alu_r4), .alu_cout(alu_cout4), .alu_zero(alu_zero4), .alu_sign(alu_sign4)
   );

   // ---------------- NIBBLES = 2 instance ----------------
   logic        in_valid2, in_ready2, cin2, l2, out_valid2, out_ready2;
   logic [1:0]  aluop2, alu_op2;
   logic [7:0]  a2, b2, result2;
   logic        cout2, zero2, sign2, err2;
   logic [3:0]  alu_a2, alu_b2, alu_r2;
   logic        alu_cin2, alu_l2, alu_cout2, alu_zero2, alu_sign2;

   always_comb {alu_cout2, alu_zero2, alu_sign2, alu_r2} =
      alu_model(alu_a2, alu_b2, alu_cin2, alu_l2, alu_op2);

   alu_nibble_seq #(.NIBBLES(2)) u_dut2 (
      .clk(clk), .reset(reset),
      .in_valid(in_valid2), .in_ready(in_ready2),
      .a(a2), .b(b2), .cin(cin2), .l(l2), .aluop(aluop2),
      .out_valid(out_valid2), .out_ready(out_ready2),
      .result(result2), .cout(cout2), .zero(zero2), .sign(sign2), .err(err2),
      .alu_a(alu_a2), .alu_b(alu_b2), .alu_cin(alu_cin2), .alu_op(alu_op2), .alu_l(alu_l2),
      .alu_r(alu_r2), .alu_cout(alu_cout2), .alu_zero(alu_zero2), .alu_sign(alu_sign2)
   );

   // ---------------- helpers (stimulus only) ----------------
   task automatic start4(input logic [15:0] x, input logic [15:0] y, input logic ci,
                         input logic lm, input logic [1:0] op);
      @(negedge clk);
      a4 = x; b4 = y; cin4 = ci; l4 = lm; aluop4 = op; in_valid4 = 1'b1;
      @(posedge clk); #1;
      in_valid4 = 1'b0;
   endtask

   // Counts edges after the accept edge until out_valid is seen, logging ALU traffic
   task automatic run_until_done4(output int edges, output logic [3:0] cin_log,
                                  output logic [15:0] r_log, output int run_cycles);
      edges = 0; cin_log = '0; r_log = '0; run_cycles = 0;
      while (out_valid4 !== 1'b1 && edges < 20) begin
         if (edges < 4) begin
            cin_log[edges]      = alu_cin4;
            r_log[4*edges +: 4] = alu_r4;
         end
         run_cycles++;
         @(posedge clk); #1;
         edges++;
      end
   endtask

   task automatic consume4();
      @(negedge clk); out_ready4 = 1'b1;
      @(posedge clk); #1; out_ready4 = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;
      @(negedge clk); reset = 1'b1;
      checks++;
      if ({in_ready4, out_valid4, result4, cout4, zero4, sign4, err4} !== {2'b10, 16'h0, 4'b0000}) begin
         failures++;
         $display("FAIL reset_state4: got rdy=%b vld=%b res=%h c=%b z=%b s=%b e=%b", in_ready4,
                  out_valid4, result4, cout4, zero4, sign4, err4);
      end
      checks++;
      if ({alu_a4, alu_b4, alu_cin4, alu_l4, alu_op4} !== {4'h0, 4'h0, 1'b0, 1'b1, 2'b00}) begin
         failures++;
         $display("FAIL reset_alu_drive: got a=%h b=%h cin=%b l=%b op=%b expected 0 0 0 1 00",
                  alu_a4, alu_b4, alu_cin4, alu_l4, alu_op4);
      end
      checks++;
      if ({in_ready2, out_valid2, result2} !== {2'b10, 8'h00}) begin
         failures++;
         $display("FAIL reset_state2: got rdy=%b vld=%b res=%h", in_ready2, out_valid2, result2);
      end
   endtask

   task automatic test_add_carry();
      int e, rc; logic [3:0] cl; logic [15:0] rl;
      start4(16'h00FF, 16'h0001, 1'b0, 1'b0, 2'b10);
      run_until_done4(e, cl, rl, rc);
      checks++;
      if (e !== 4) begin failures++; $display("FAIL add_latency: got %0d expected 4", e); end
      checks++;
      if (cl !== 4'b0110) begin failures++; $display("FAIL add_cin_chain: got %b expected 0110", cl); end
      checks++;
      if ({result4, cout4, zero4, sign4, err4} !== {16'h0100, 4'b0000}) begin
         failures++;
         $display("FAIL add_result: got %h c=%b z=%b s=%b e=%b expected 0100 0 0 0 0",
                  result4, cout4, zero4, sign4, err4);
      end
      consume4();
   endtask

   task automatic test_add_wrap();
      int e, rc; logic [3:0] cl; logic [15:0] rl;
      start4(16'hFFFF, 16'h0001, 1'b0, 1'b0, 2'b10);
      run_until_done4(e, cl, rl, rc);
      checks++;
      if ({result4, cout4, zero4, sign4} !== {16'h0000, 3'b110}) begin
         failures++;
         $display("FAIL add_wrap: got %h c=%b z=%b s=%b expected 0000 1 1 0", result4, cout4, zero4, sign4);
      end
      consume4();
      // carry-in feeds the lowest nibble: 0x7FFF + 0 + 1 = 0x8000
      start4(16'h7FFF, 16'h0000, 1'b1, 1'b0, 2'b10);
      run_until_done4(e, cl, rl, rc);
      checks++;
      if ({result4, cout4, zero4, sign4} !== {16'h8000, 3'b001}) begin
         failures++;
         $display("FAIL add_cin_sign: got %h c=%b z=%b s=%b expected 8000 0 0 1", result4, cout4, zero4, sign4);
      end
      consume4();
   endtask

   task automatic test_logic();
      int e, rc; logic [3:0] cl; logic [15:0] rl;
      start4(16'hF0F0, 16'hFF00, 1'b1, 1'b1, 2'b00);
      run_until_done4(e, cl, rl, rc);
      checks++;
      if (result4 !== rl || result4 !== 16'hF000) begin
         failures++;
         $display("FAIL logic_and: got %h alu replies %h expected F000", result4, rl);
      end
      checks++;
      if (cl !== 4'b0000 || cout4 !== 1'b0) begin
         failures++;
         $display("FAIL logic_no_carry: got cin=%b cout=%b expected 0000 0", cl, cout4);
      end
      consume4();
      start4(16'h1234, 16'h1234, 1'b0, 1'b1, 2'b10);
      run_until_done4(e, cl, rl, rc);
      checks++;
      if ({result4, zero4, sign4} !== {16'h0000, 2'b10}) begin
         failures++;
         $display("FAIL logic_xor_zero: got %h z=%b s=%b expected 0000 1 0", result4, zero4, sign4);
      end
      consume4();
   endtask

   task automatic test_illegal();
      int e, rc; logic [3:0] cl; logic [15:0] rl;
      start4(16'h1234, 16'h4321, 1'b1, 1'b0, 2'b00);
      // DONE is entered directly on the accept edge, so no RUN cycle is seen
      checks++;
      if (alu_l4 !== 1'b1 || alu_a4 !== 4'h0) begin
         failures++;
         $display("FAIL illegal_no_run: got alu_l=%b alu_a=%h expected 1 0", alu_l4, alu_a4);
      end
      run_until_done4(e, cl, rl, rc);
      checks++;
      if (e !== 0 || rc !== 0) begin
         failures++;
         $display("FAIL illegal_latency: got edges=%0d run=%0d expected 0 0", e, rc);
      end
      checks++;
      if ({err4, result4, cout4, zero4, sign4} !== {1'b1, 16'h0000, 3'b000}) begin
         failures++;
         $display("FAIL illegal_flags: got e=%b res=%h c=%b z=%b s=%b expected 1 0000 0 0 0",
                  err4, result4, cout4, zero4, sign4);
      end
      consume4();
   endtask

   task automatic test_backpressure();
      int e, rc; logic [3:0] cl; logic [15:0] rl;
      start4(16'h1234, 16'h1111, 1'b0, 1'b0, 2'b10);
      run_until_done4(e, cl, rl, rc);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({out_valid4, in_ready4, result4, cout4, zero4, sign4, err4} !== {2'b10, 16'h2345, 4'b0000}) begin
            failures++;
            $display("FAIL hold_cycle%0d: got vld=%b rdy=%b res=%h expected 1 0 2345", i,
                     out_valid4, in_ready4, result4);
         end
         // a request during DONE must be ignored
         in_valid4 = (i == 2);
         @(posedge clk); #1;
      end
      in_valid4 = 1'b0;
      consume4();
      checks++;
      if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0) begin
         failures++;
         $display("FAIL release: got rdy=%b vld=%b expected 1 0", in_ready4, out_valid4);
      end
   endtask

   task automatic test_midrun_reset();
      int seen;
      start4(16'hFFFF, 16'h0001, 1'b0, 1'b0, 2'b10);
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         if (out_valid4 === 1'b1) seen++;
         @(posedge clk); #1;
      end
      checks++;
      if (seen !== 0 || result4 !== 16'h0000 || in_ready4 !== 1'b1) begin
         failures++;
         $display("FAIL midrun_reset: got valid_cycles=%0d res=%h rdy=%b expected 0 0000 1",
                  seen, result4, in_ready4);
      end
   endtask

   task automatic test_nib2();
      int e;
      @(negedge clk);
      a2 = 8'h7F; b2 = 8'h01; cin2 = 1'b0; l2 = 1'b0; aluop2 = 2'b10; in_valid2 = 1'b1;
      @(posedge clk); #1;
      in_valid2 = 1'b0;
      e = 0;
      while (out_valid2 !== 1'b1 && e < 20) begin
         @(posedge clk); #1;
         e++;
      end
      checks++;
      if (e !== 2) begin failures++; $display("FAIL nib2_latency: got %0d expected 2", e); end
      checks++;
      if ({result2, sign2, cout2, zero2} !== {8'h80, 3'b100}) begin
         failures++;
         $display("FAIL nib2_result: got %h s=%b c=%b z=%b expected 80 1 0 0", result2, sign2, cout2, zero2);
      end
      @(negedge clk); out_ready2 = 1'b1;
      @(posedge clk); #1; out_ready2 = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; l4 = 1'b0; aluop4 = 2'b00;
      in_valid2 = 1'b0; out_ready2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0; l2 = 1'b0; aluop2 = 2'b00;
      test_reset();
      test_add_carry();
      test_add_wrap();
      test_logic();
      test_illegal();
      test_backpressure();
      test_midrun_reset();
      test_nib2();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
